// File: rtl/async_fifo_core_if.sv
// Handshake/data bundle for async_fifo_core: producer side (wdata/winc/wfull)
// and consumer side (rdata/rinc/rempty) in one interface.
// Optional macro FIFO_COUNT_EN adds the occupancy signal 'count'.
interface async_fifo_core_if #(
    parameter int unsigned DSIZE    = 32,
    parameter int unsigned ADDRSIZE = 5
);
    logic [DSIZE-1:0]  wdata;
    logic              winc;
    logic              wfull;
    logic [DSIZE-1:0]  rdata;
    logic              rinc;
    logic              rempty;
`ifdef FIFO_COUNT_EN
    logic [ADDRSIZE:0] count;
`endif

`ifdef FIFO_COUNT_EN
    // Producer/consumer logic driving the FIFO
    modport master (
        output wdata, winc, rinc,
        input  wfull, rdata, rempty, count
    );

    // The FIFO itself
    modport slave (
        input  wdata, winc, rinc,
        output wfull, rdata, rempty, count
    );
`else
    // Producer/consumer logic driving the FIFO
    modport master (
        output wdata, winc, rinc,
        input  wfull, rdata, rempty
    );

    // The FIFO itself
    modport slave (
        input  wdata, winc, rinc,
        output wfull, rdata, rempty
    );
`endif
endinterface

// File: rtl/async_fifo_core.sv
// Single-clock first-word-fall-through FIFO, 2^ADDRSIZE x DSIZE.
// Binary read/write pointers carry an extra wrap bit to tell full from empty.
// Optional macro FIFO_COUNT_EN exposes occupancy (wptr - rptr) on bus.count.
module async_fifo_core #(
    parameter int unsigned DSIZE    = 32,
    parameter int unsigned ADDRSIZE = 5
) (
    input  logic               clk,
    input  logic               rst,
    async_fifo_core_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDRSIZE;
    localparam int unsigned PTRW  = ADDRSIZE + 1;

    logic [DSIZE-1:0]    mem_q [DEPTH];

    logic [PTRW-1:0]     wptr_q;
    logic [PTRW-1:0]     wptr_d;
    logic [PTRW-1:0]     rptr_q;
    logic [PTRW-1:0]     rptr_d;

    logic [ADDRSIZE-1:0] waddr_c;
    logic [ADDRSIZE-1:0] raddr_c;
    logic                full_c;
    logic                empty_c;
    logic                wr_en_c;
    logic                rd_en_c;

    // Status flags derived from the registered pointers
    always_comb begin
        waddr_c = wptr_q[ADDRSIZE-1:0];
        raddr_c = rptr_q[ADDRSIZE-1:0];
        empty_c = (wptr_q == rptr_q);
        full_c  = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
                  (waddr_c == raddr_c);
    end

    // Accept requests only when the flag allows; blocked requests are dropped
    always_comb begin
        wr_en_c = bus.winc && !full_c;
        rd_en_c = bus.rinc && !empty_c;
    end

    // Next-state pointers; both may advance in the same cycle
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en_c) begin
            wptr_d = wptr_q + PTRW'(1);
        end
        if (rd_en_c) begin
            rptr_d = rptr_q + PTRW'(1);
        end
    end

    // Pointer registers; reset discards all contents
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en_c && !rst) begin
            mem_q[waddr_c] <= bus.wdata;
        end
    end

    // Head-of-queue data falls through; zero while empty
    always_comb begin
        bus.wfull  = full_c;
        bus.rempty = empty_c;
        bus.rdata  = empty_c ? '0 : mem_q[raddr_c];
    end

`ifdef FIFO_COUNT_EN
    // Occupancy, same timing as the flags
    always_comb begin
        bus.count = wptr_q - rptr_q;
    end
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// Directed self-checking bench for async_fifo_core.
// Build with +define+FIFO_COUNT_EN to also check the occupancy output.
module tb_async_fifo_core;
    localparam int unsigned DSIZE    = 32;
    localparam int unsigned ADDRSIZE = 5;
    localparam int unsigned DEPTH    = 1 << ADDRSIZE;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    async_fifo_core_if #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) bus ();

    async_fifo_core #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs settle 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.winc  = 1'b0;
        bus.rinc  = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL reset_rempty got=%0b exp=1", bus.rempty); end
        checks++; if (bus.wfull !== 1'b0) begin failures++; $display("FAIL reset_wfull got=%0b exp=0", bus.wfull); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
`ifdef FIFO_COUNT_EN
        checks++; if (bus.count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
`endif
    endtask

    task automatic test_fwft();
        bus.winc  = 1'b1;
        bus.wdata = 32'h0000BBBB;
        step();
        checks++; if (bus.rempty !== 1'b0) begin failures++; $display("FAIL fwft_rempty got=%0b exp=0", bus.rempty); end
        checks++; if (bus.rdata !== 32'h0000BBBB) begin failures++; $display("FAIL fwft_head1 got=%h exp=0000bbbb", bus.rdata); end
        bus.wdata = 32'h00010001;
        step();
        checks++; if (bus.rdata !== 32'h0000BBBB) begin failures++; $display("FAIL fwft_head2 got=%h exp=0000bbbb", bus.rdata); end
`ifdef FIFO_COUNT_EN
        checks++; if (bus.count !== 6'd2) begin failures++; $display("FAIL fwft_count got=%0d exp=2", bus.count); end
`endif
        idle();
        bus.rinc = 1'b1;
        step();
        idle();
        checks++; if (bus.rdata !== 32'h00010001) begin failures++; $display("FAIL fwft_pop got=%h exp=00010001", bus.rdata); end
        checks++; if (bus.rempty !== 1'b0) begin failures++; $display("FAIL fwft_pop_rempty got=%0b exp=0", bus.rempty); end
    endtask

    task automatic test_simultaneous();
        bus.winc  = 1'b1;
        bus.rinc  = 1'b1;
        bus.wdata = 32'h0100CCCC;
        step();
        idle();
        checks++; if (bus.rdata !== 32'h0100CCCC) begin failures++; $display("FAIL simul_head got=%h exp=0100cccc", bus.rdata); end
        checks++; if (bus.rempty !== 1'b0) begin failures++; $display("FAIL simul_rempty got=%0b exp=0", bus.rempty); end
`ifdef FIFO_COUNT_EN
        checks++; if (bus.count !== 6'd1) begin failures++; $display("FAIL simul_count got=%0d exp=1", bus.count); end
`endif
        bus.rinc = 1'b1;
        step();
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL drain_rempty got=%0b exp=1", bus.rempty); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL drain_rdata got=%h exp=0", bus.rdata); end
        step();
        idle();
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL underrun_rempty got=%0b exp=1", bus.rempty); end
        checks++; if (bus.wfull !== 1'b0) begin failures++; $display("FAIL underrun_wfull got=%0b exp=0", bus.wfull); end
        // Simultaneous request while empty: only the write happens
        bus.winc  = 1'b1;
        bus.rinc  = 1'b1;
        bus.wdata = 32'h00005555;
        step();
        idle();
        checks++; if (bus.rdata !== 32'h00005555) begin failures++; $display("FAIL empty_simul_head got=%h exp=00005555", bus.rdata); end
        bus.rinc = 1'b1;
        step();
        idle();
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL empty_simul_drain got=%0b exp=1", bus.rempty); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            bus.winc  = 1'b1;
            bus.wdata = 32'(i);
            step();
            if (i == DEPTH - 2) begin
                checks++; if (bus.wfull !== 1'b0) begin failures++; $display("FAIL full_early got=%0b exp=0", bus.wfull); end
            end
        end
        checks++; if (bus.wfull !== 1'b1) begin failures++; $display("FAIL full_flag got=%0b exp=1", bus.wfull); end
`ifdef FIFO_COUNT_EN
        checks++; if (bus.count !== 6'd32) begin failures++; $display("FAIL full_count got=%0d exp=32", bus.count); end
`endif
        bus.wdata = 32'hDEADBEEF;
        step();
        idle();
        checks++; if (bus.wfull !== 1'b1) begin failures++; $display("FAIL overflow_wfull got=%0b exp=1", bus.wfull); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL overflow_head got=%h exp=0", bus.rdata); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.rdata !== 32'(i)) begin failures++; $display("FAIL full_read[%0d] got=%h exp=%h", i, bus.rdata, 32'(i)); end
            bus.rinc = 1'b1;
            step();
        end
        idle();
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL full_drained got=%0b exp=1", bus.rempty); end
    endtask

    task automatic test_full_simultaneous();
        for (int i = 0; i < DEPTH; i++) begin
            bus.winc  = 1'b1;
            bus.wdata = 32'h100 + 32'(i);
            step();
        end
        bus.winc  = 1'b1;
        bus.rinc  = 1'b1;
        bus.wdata = 32'h0000AAAA;
        step();
        idle();
        checks++; if (bus.wfull !== 1'b0) begin failures++; $display("FAIL fullsim_wfull got=%0b exp=0", bus.wfull); end
        checks++; if (bus.rdata !== 32'h101) begin failures++; $display("FAIL fullsim_head got=%h exp=00000101", bus.rdata); end
`ifdef FIFO_COUNT_EN
        checks++; if (bus.count !== 6'd31) begin failures++; $display("FAIL fullsim_count got=%0d exp=31", bus.count); end
`endif
        for (int i = 1; i < DEPTH; i++) begin
            checks++; if (bus.rdata !== 32'h100 + 32'(i)) begin failures++; $display("FAIL fullsim_read[%0d] got=%h exp=%h", i, bus.rdata, 32'h100 + 32'(i)); end
            bus.rinc = 1'b1;
            step();
        end
        idle();
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL fullsim_drained got=%0b exp=1", bus.rempty); end
    endtask

    task automatic test_back_to_back();
        logic [DSIZE-1:0] q [$];
        int written;
        int read_cnt;
        int cyc;
        bit do_w;
        bit do_r;
        written  = 0;
        read_cnt = 0;
        cyc      = 0;
        while ((read_cnt < 100) && (cyc < 400)) begin
            bus.winc  = (written < 100);
            bus.wdata = 32'h00A00000 + 32'(written);
            bus.rinc  = ((cyc % 3) != 0) || (written >= 100);
            do_w = bus.winc && (q.size() < DEPTH);
            do_r = bus.rinc && (q.size() > 0);
            if (do_r) begin
                void'(q.pop_front());
                read_cnt++;
            end
            if (do_w) begin
                q.push_back(bus.wdata);
                written++;
            end
            step();
            cyc++;
            if (q.size() > 0) begin
                checks++; if (bus.rdata !== q[0]) begin failures++; $display("FAIL stream_head cyc=%0d got=%h exp=%h", cyc, bus.rdata, q[0]); end
            end else begin
                checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL stream_empty cyc=%0d got=%0b exp=1", cyc, bus.rempty); end
            end
        end
        idle();
        checks++; if (read_cnt !== 100) begin failures++; $display("FAIL stream_timeout got=%0d exp=100", read_cnt); end
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL stream_end_rempty got=%0b exp=1", bus.rempty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            bus.winc  = 1'b1;
            bus.wdata = 32'h00B00000 + 32'(i);
            step();
        end
        rst  = 1'b1;
        bus.rinc = 1'b1;
        bus.wdata = 32'h0BADF00D;
        step();
        rst = 1'b0;
        idle();
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL rstmid_rempty got=%0b exp=1", bus.rempty); end
        checks++; if (bus.wfull !== 1'b0) begin failures++; $display("FAIL rstmid_wfull got=%0b exp=0", bus.wfull); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL rstmid_rdata got=%h exp=0", bus.rdata); end
`ifdef FIFO_COUNT_EN
        checks++; if (bus.count !== 6'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", bus.count); end
`endif
        for (int i = 0; i < 3; i++) begin
            bus.winc  = 1'b1;
            bus.wdata = 32'h00C00000 + 32'(i);
            step();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.rdata !== 32'h00C00000 + 32'(i)) begin failures++; $display("FAIL rstmid_read[%0d] got=%h exp=%h", i, bus.rdata, 32'h00C00000 + 32'(i)); end
            bus.rinc = 1'b1;
            step();
        end
        idle();
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL rstmid_drained got=%0b exp=1", bus.rempty); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        test_reset();
        test_fwft();
        test_simultaneous();
        test_full();
        test_full_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
